ip_input_conditioner: RTL and testbench

- Sits directly downstream of the single-ended input buffer wrapper; consumes its buffered pin output.
- Synchronises the asynchronous pin into `clk`, rejects glitches with a debounce state machine, and presents a clean level plus one-cycle rise/fall strobes to core logic.
- Used on slow control and status inputs (enables, power-good, external triggers).

---
 rtl/ip_input_conditioner.sv | 170 +++++++++++++++++
 tb/tb_ip_input_conditioner.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/ip_input_conditioner.sv
// ip_input_conditioner
//   Synchronises an asynchronous buffered pin into clk, debounces it with a
//   two-state qualifier and presents a clean level plus one-cycle rise/fall
//   strobes. All outputs are registered.
//   Optional build macro: IP_INPUT_GLITCH_CNT_EN adds a saturating 8-bit
//   count of rejected glitches (glitch_cnt_o) with a synchronous clear
//   (glitch_clr_i).
`timescale 1ns/1ps

module ip_input_conditioner #(
  parameter int   SYNC_STAGES     = 2,     // 2..4
  parameter int   DEBOUNCE_CYCLES = 16,    // 1..65535
  parameter logic INIT_LEVEL      = 1'b0
) (
  input  logic       clk,
  input  logic       rst,           // synchronous, active-low
  input  logic       din_i,
  input  logic       tick_i,
`ifdef IP_INPUT_GLITCH_CNT_EN
  input  logic       glitch_clr_i,
  output logic [7:0] glitch_cnt_o,
`endif
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic       busy_o
);

  // Counter only needs to reach DEBOUNCE_CYCLES, never beyond.
  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_TARGET = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);

  typedef enum logic {
    STABLE  = 1'b0,
    QUALIFY = 1'b1
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   s;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d, cnt_inc;
  logic             level_q, level_d;
  logic             rise_q, rise_d;
  logic             fall_q, fall_d;
  logic             busy_q, busy_d;
  logic             commit;

  // Synchroniser shift: only stage 0 sees the asynchronous pin.
  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], din_i};
  end

  // Synchroniser chain advances every clock regardless of tick_i.
  always_ff @(posedge clk) begin
    if (!rst) begin
      sync_q <= {SYNC_STAGES{INIT_LEVEL}};
    end else begin
      sync_q <= sync_d;
    end
  end

  assign s = sync_q[SYNC_STAGES-1];

  // Debounce next-state: qualify a differing level for DEBOUNCE_CYCLES ticks.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    commit  = 1'b0;
    cnt_inc = cnt_q + CNT_ONE;

    case (state_q)
      STABLE: begin
        if (tick_i && (s != level_q)) begin
          if (CNT_TARGET == CNT_ONE) begin
            commit = 1'b1;
          end else begin
            cnt_d   = CNT_ONE;
            state_d = QUALIFY;
          end
        end
      end
      QUALIFY: begin
        if (tick_i) begin
          if (s != level_q) begin
            if (cnt_inc == CNT_TARGET) begin
              commit = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end else begin
            // Pin returned to the accepted level before qualifying: glitch.
            cnt_d   = '0;
            state_d = STABLE;
          end
        end
      end
      default: begin
        cnt_d   = '0;
        state_d = STABLE;
      end
    endcase

    if (commit) begin
      level_d = s;
      cnt_d   = '0;
      state_d = STABLE;
      rise_d  = s;
      fall_d  = ~s;
    end

    busy_d = (state_d == QUALIFY);
  end

  // Debounce state, counter and registered outputs.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= STABLE;
      cnt_q   <= '0;
      level_q <= INIT_LEVEL;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      busy_q  <= busy_d;
    end
  end

  assign level_o = level_q;
  assign rise_o  = rise_q;
  assign fall_o  = fall_q;
  assign busy_o  = busy_q;

`ifdef IP_INPUT_GLITCH_CNT_EN
  logic [7:0] glitch_cnt_q, glitch_cnt_d;
  logic       reject;

  // A rejection is a tick in QUALIFY where the pin is back at the old level.
  always_comb begin
    reject       = (state_q == QUALIFY) && tick_i && (s == level_q);
    glitch_cnt_d = glitch_cnt_q;
    if (glitch_clr_i) begin
      glitch_cnt_d = 8'd0;
    end else if (reject && (glitch_cnt_q != 8'hFF)) begin
      glitch_cnt_d = glitch_cnt_q + 8'd1;
    end
  end

  // Saturating glitch counter; clear has priority over increment.
  always_ff @(posedge clk) begin
    if (!rst) begin
      glitch_cnt_q <= 8'd0;
    end else begin
      glitch_cnt_q <= glitch_cnt_d;
    end
  end

  assign glitch_cnt_o = glitch_cnt_q;
`endif

endmodule

// File: tb/tb_ip_input_conditioner.sv
// Directed bench for ip_input_conditioner at default parameters
// (SYNC_STAGES=2, DEBOUNCE_CYCLES=16, INIT_LEVEL=0).
`timescale 1ns/1ps

module tb_ip_input_conditioner;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic din_i = 1'b0;
  logic tick_i = 1'b1;
  logic level_o, rise_o, fall_o, busy_o;
`ifdef IP_INPUT_GLITCH_CNT_EN
  logic       glitch_clr_i = 1'b0;
  logic [7:0] glitch_cnt_o;
`endif

  ip_input_conditioner dut (
    .clk          (clk),
    .rst          (rst),
    .din_i        (din_i),
    .tick_i       (tick_i),
`ifdef IP_INPUT_GLITCH_CNT_EN
    .glitch_clr_i (glitch_clr_i),
    .glitch_cnt_o (glitch_cnt_o),
`endif
    .level_o      (level_o),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic din;
    logic tick;
    logic level;
    logic rise;
    logic fall;
    logic busy;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic void add(logic d, logic t, logic l, logic r, logic f, logic b);
    vec_t v;
    v.din = d; v.tick = t; v.level = l; v.rise = r; v.fall = f; v.busy = b;
    vecs.push_back(v);
  endfunction

  // Advance one clock and sample 1 ns after the active edge.
  task automatic edge1();
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string name, input logic l, input logic r,
                            input logic f, input logic b);
    checks++;
    if ({level_o, rise_o, fall_o, busy_o} !== {l, r, f, b}) begin
      errors++;
      $display("FAIL %s: level/rise/fall/busy got %b%b%b%b expected %b%b%b%b",
               name, level_o, rise_o, fall_o, busy_o, l, r, f, b);
    end else begin
      $display("ok   %s: level/rise/fall/busy %b%b%b%b", name, level_o, rise_o, fall_o, busy_o);
    end
  endtask

  task automatic check_val(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("ok   %s: %0d", name, act);
    end
  endtask

  // Hard stop if something hangs.
  initial begin
    #500000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int rise_at;
    int rise_seen;
    int busy_drop;

    // Per-edge vectors; index i is the i-th edge of the segment.
    // Rising step held: s=1 after edge 2, count 1..16 on edges 3..18.
    for (int i = 1; i <= 20; i++) add(1'b1, 1'b1, i >= 18, i == 18, 1'b0, (i >= 3) && (i <= 17));
    // Falling step held.
    for (int i = 1; i <= 20; i++) add(1'b0, 1'b1, i < 18, 1'b0, i == 18, (i >= 3) && (i <= 17));
    // 10-cycle high glitch: qualifies on edges 3..12, rejected on edge 13.
    for (int i = 1; i <= 10; i++) add(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, i >= 3);
    for (int i = 11; i <= 20; i++) add(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, (i == 11) || (i == 12));

    // Reset with pin high: chain and level held at INIT_LEVEL.
    rst = 1'b0; din_i = 1'b1; tick_i = 1'b1;
    repeat (3) edge1();
    check_outs("reset_din_high", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;

    for (int k = 0; k < vecs.size(); k++) begin
      din_i  = vecs[k].din;
      tick_i = vecs[k].tick;
      edge1();
      check_outs($sformatf("vec%0d", k), vecs[k].level, vecs[k].rise, vecs[k].fall, vecs[k].busy);
    end

`ifdef IP_INPUT_GLITCH_CNT_EN
    check_val("glitch_cnt_after_pulse", glitch_cnt_o, 1);
`endif

    // Tick 1-in-4: qualifying ticks on edges 4,8,..,64 -> commit on edge 64.
    din_i = 1'b1;
    rise_at = 0; rise_seen = 0; busy_drop = 0;
    for (int k = 1; k <= 120; k++) begin
      tick_i = (k % 4 == 0);
      edge1();
      if ((rise_at == 0) && (level_o == 1'b1)) begin
        rise_at   = k;
        rise_seen = rise_o;
      end
      if ((k >= 4) && (k <= 63) && (busy_o != 1'b1)) busy_drop++;
    end
    tick_i = 1'b1;
    check_val("tick4_commit_edge", rise_at, 64);
    check_val("tick4_rise_with_level", rise_seen, 1);
    check_val("tick4_busy_held_between_ticks", busy_drop, 0);

    // Reset in the middle of qualification (counter = 8).
    rst = 1'b0; din_i = 1'b0;
    repeat (2) edge1();
    rst = 1'b1;
    check_outs("reset2", 1'b0, 1'b0, 1'b0, 1'b0);
    din_i = 1'b1;
    repeat (10) edge1();
    check_outs("qualify_cnt8", 1'b0, 1'b0, 1'b0, 1'b1);
    rst = 1'b0;
    edge1();
    check_outs("reset_mid_qualify", 1'b0, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    rise_at = 0; rise_seen = 0;
    for (int k = 1; k <= 40; k++) begin
      edge1();
      if ((rise_at == 0) && (level_o == 1'b1)) begin
        rise_at   = k;
        rise_seen = rise_o;
      end
    end
    check_val("restart_commit_edge", rise_at, 18);
    check_val("restart_rise", rise_seen, 1);
    check_outs("restart_settled", 1'b1, 1'b0, 1'b0, 1'b0);

`ifdef IP_INPUT_GLITCH_CNT_EN
    // Saturation: 300 short glitches, each rejected on its 6th edge.
    rst = 1'b0; din_i = 1'b0;
    repeat (2) edge1();
    rst = 1'b1;
    check_val("glitch_cnt_reset", glitch_cnt_o, 0);
    for (int g = 0; g < 300; g++) begin
      din_i = 1'b1; repeat (3) edge1();
      din_i = 1'b0; repeat (5) edge1();
    end
    check_val("glitch_cnt_saturated", glitch_cnt_o, 255);
    check_outs("glitch_level_unchanged", 1'b0, 1'b0, 1'b0, 1'b0);
    // Clear coincident with a rejection edge.
    din_i = 1'b1; repeat (3) edge1();
    din_i = 1'b0; repeat (2) edge1();
    glitch_clr_i = 1'b1;
    edge1();
    glitch_clr_i = 1'b0;
    check_val("glitch_clr_wins", glitch_cnt_o, 0);
    repeat (2) edge1();
    din_i = 1'b1; repeat (3) edge1();
    din_i = 1'b0; repeat (5) edge1();
    check_val("glitch_cnt_after_clear", glitch_cnt_o, 1);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
